// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the memory (slave).
`timescale 1ns/1ps
interface instr_mem_if #(
    parameter int ADDR_W = 16,
    parameter int IR_W   = 8
);
    // Handshake: mem_rd_req is a one-cycle strobe with mem_addr stable in that cycle and held
    // until the next fetch; the memory answers in a later cycle with a one-cycle mem_rd_valid
    // carrying mem_rd_data. There is no back-pressure, and mem_rd_valid is only honoured
    // while the fetch unit is waiting for that answer.
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rd_valid;
    logic [IR_W-1:0]   mem_rd_data;

    modport master (
        output mem_addr,
        output mem_rd_req,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_req,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Owns the PC and fetches one instruction word per request into IR for the microcoded controller.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int IR_W     = 8,
    parameter int TIMEOUT  = 15,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_data,
    instr_mem_if.master       mem,
    output logic [IR_W-1:0]   IR,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        state_dbg
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              fetch_ok;

    assign fetch_ok = (state_q == S_WAIT) && mem.mem_rd_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
        fetch_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    state_d    = S_REQ;
                    mem_addr_d = pc_q;
                end
            end
            S_REQ: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Data arriving on the final timeout cycle still wins over the abort.
                if (mem.mem_rd_valid) begin
                    ir_d       = mem.mem_rd_data;
                    ir_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One PC source per cycle, so a load or explicit increment suppresses the auto-increment.
    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = pc_load_data;
        end else if (pc_inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end else if ((AUTO_INC != 0) && fetch_ok) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mem_addr_q  <= '0;
            pc_q        <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_rd_req = (state_q == S_REQ);
    assign IR             = ir_q;
    assign ir_valid       = ir_valid_q;
    assign fetch_err      = fetch_err_q;
    assign busy           = (state_q == S_REQ) || (state_q == S_WAIT);
    assign pc             = pc_q;
    assign state_dbg      = state_q;
endmodule
